// File: rtl/reg_bank_write_arbiter_if.sv
// Write-request bus between the control masters and the register-bank arbiter.
// The master drives the requests and the hold. The slave returns the grant,
// the write strobes and the bank contents.
interface reg_bank_write_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2
);
  logic                         hold;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*ADDR_W-1:0]    req_addr;
  logic [NUM_REQ*DATA_W-1:0]    req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REGS-1:0]          reg_en;
  logic [DATA_W-1:0]            reg_d;
  logic [NUM_REGS*DATA_W-1:0]   reg_q;
  logic                         busy;

  modport master (
    output hold, req_valid, req_addr, req_data,
    input  req_ready, reg_en, reg_d, reg_q, busy
  );

  modport slave (
    input  hold, req_valid, req_addr, req_data,
    output req_ready, reg_en, reg_d, reg_q, busy
  );
endinterface

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter in front of a bank of enable-gated registers.
// One grant per cycle. The grant is registered into a one-hot strobe plus its
// data, and that strobe loads the bank one edge later.
module reg_bank_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2
) (
  input logic clk,
  input logic reset,
  reg_bank_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]                 rr_ptr_reg;
  logic [PTR_W-1:0]                 win_idx;
  logic [NUM_REQ-1:0]               grant;
  logic                             found;
  int                               idx;
  logic [ADDR_W-1:0]                win_addr;
  logic [DATA_W-1:0]                win_data;
  logic [NUM_REGS-1:0]              en_next;
  logic [NUM_REGS-1:0]              reg_en_reg;
  logic [DATA_W-1:0]                reg_d_reg;
  logic                             busy_reg;
  logic [NUM_REGS-1:0][DATA_W-1:0]  bank_reg;

  // Round-robin search from rr_ptr upward; the grant never looks at addr/data.
  always_comb begin
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (!bus.hold && !reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
        if (!found && bus.req_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          win_idx    = PTR_W'(idx);
        end
      end
    end
  end

  assign bus.req_ready = grant;
  assign win_addr      = bus.req_addr[win_idx*ADDR_W +: ADDR_W];
  assign win_data      = bus.req_data[win_idx*DATA_W +: DATA_W];

  // Decode the winning address; an out-of-range index matches no register,
  // so such a write completes its handshake but is dropped.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign en_next[gi] = found && (win_addr == ADDR_W'(gi));
    end
  endgenerate

  // Advance the pointer past the winner on each handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg <= '0;
    end else if (found) begin
      rr_ptr_reg <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Strobe stage: register the write strobe and data; data holds when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_en_reg <= '0;
      reg_d_reg  <= '0;
      busy_reg   <= 1'b0;
    end else begin
      reg_en_reg <= en_next;
      busy_reg   <= |en_next;
      if (found) begin
        reg_d_reg <= win_data;
      end
    end
  end

  // Bank: each register loads reg_d when its strobe is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_reg <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (reg_en_reg[r]) begin
          bank_reg[r] <= reg_d_reg;
        end
      end
    end
  end

  assign bus.reg_en = reg_en_reg;
  assign bus.reg_d  = reg_d_reg;
  assign bus.busy   = busy_reg;
  assign bus.reg_q  = bank_reg;
endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Directed bench for reg_bank_write_arbiter: reset, single write, round robin,
// hold, same-address collision and reset in the middle of a write.
module tb_reg_bank_write_arbiter;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int passes = 0;

  reg_bank_write_arbiter_if #(.NUM_REQ(4), .NUM_REGS(4), .DATA_W(8), .ADDR_W(2)) bus ();

  reg_bank_write_arbiter #(.NUM_REQ(4), .NUM_REGS(4), .DATA_W(8), .ADDR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    // 1: reset held two cycles with all valids high
    reset         = 1'b1;
    bus.hold      = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    tick(); tick(); #1;
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_reg_en", 32'(bus.reg_en), 32'h0);
    chk("rst_reg_q", bus.reg_q, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    $display("reset: ready=%b reg_en=%b reg_q=%h busy=%b", bus.req_ready, bus.reg_en, bus.reg_q, bus.busy);
    bus.req_valid = 4'b0000;
    tick();
    reset = 1'b0;

    // 2: single write, req0 -> reg2 = 0xAA
    tick();
    bus.req_valid = 4'b0001;
    bus.req_addr  = 8'b00_00_00_10;
    bus.req_data  = 32'h000000AA;
    #1 chk("single_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    chk("single_reg_en", 32'(bus.reg_en), 32'h4);
    chk("single_reg_d", 32'(bus.reg_d), 32'hAA);
    chk("single_busy", 32'(bus.busy), 32'h1);
    tick(); #1;
    chk("single_reg_q", bus.reg_q, 32'h00AA0000);
    chk("single_idle_en", 32'(bus.reg_en), 32'h0);
    chk("single_idle_d", 32'(bus.reg_d), 32'hAA);
    chk("single_idle_busy", 32'(bus.busy), 32'h0);
    $display("single: reg_q=%h", bus.reg_q);

    // 3: round robin after a fresh reset; all four requesters continuously
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_addr  = 8'b11_10_01_00;
    bus.req_data  = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      #1;
      chk($sformatf("rr_ready_%0d", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
      if (k > 0) chk($sformatf("rr_reg_en_%0d", k), 32'(bus.reg_en), 32'(1 << ((k - 1) % 4)));
      $display("rr cycle %0d: ready=%b reg_en=%b", k, bus.req_ready, bus.reg_en);
    end
    tick();
    bus.req_valid = 4'b0000;
    #1 chk("rr_last_en", 32'(bus.reg_en), 32'h1);
    tick(); #1;
    chk("rr_reg_q", bus.reg_q, 32'h13121110);
    $display("rr: reg_q=%h", bus.reg_q);

    // 4: hold blocks requester 1 for three cycles
    bus.hold      = 1'b1;
    bus.req_valid = 4'b0010;
    bus.req_data  = 32'h1312FF10;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      #1 chk($sformatf("hold_ready_%0d", k), 32'(bus.req_ready), 32'h0);
    end
    tick(); #1;
    chk("hold_reg_q", bus.reg_q, 32'h13121110);
    chk("hold_reg_en", 32'(bus.reg_en), 32'h0);
    bus.hold = 1'b0;
    #1 chk("hold_release_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    chk("hold_reg_en_after", 32'(bus.reg_en), 32'h2);
    chk("hold_reg_d_after", 32'(bus.reg_d), 32'hFF);
    tick(); #1;
    chk("hold_reg_q_after", bus.reg_q, 32'h1312FF10);
    $display("hold: reg_q=%h", bus.reg_q);

    // 5: req2 then req3 both write reg0, back to back
    bus.req_valid = 4'b0100;
    bus.req_addr  = 8'b11_00_01_00;
    bus.req_data  = 32'h1355FF10;
    #1 chk("coll_ready_a", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 4'b1000;
    bus.req_addr  = 8'b00_00_01_00;
    bus.req_data  = 32'h6655FF10;
    #1;
    chk("coll_ready_b", 32'(bus.req_ready), 32'h8);
    chk("coll_reg_d_a", 32'(bus.reg_d), 32'h55);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    chk("coll_reg_q0_a", 32'(bus.reg_q[7:0]), 32'h55);
    chk("coll_reg_en_b", 32'(bus.reg_en), 32'h1);
    chk("coll_reg_d_b", 32'(bus.reg_d), 32'h66);
    tick(); #1;
    chk("coll_reg_q0_b", 32'(bus.reg_q[7:0]), 32'h66);
    chk("coll_busy", 32'(bus.busy), 32'h0);
    $display("collision: reg_q=%h", bus.reg_q);

    // 6: reset while reg_en=1000; the write to reg3 must be discarded
    bus.req_valid = 4'b0001;
    bus.req_addr  = 8'b00_00_01_11;
    bus.req_data  = 32'h66550077;
    #1 chk("mid_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    chk("mid_reg_en", 32'(bus.reg_en), 32'h8);
    chk("mid_busy", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    bus.req_valid = 4'b1001;
    #1;
    chk("mid_rst_reg_en", 32'(bus.reg_en), 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_reg_d", 32'(bus.reg_d), 32'h0);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    tick(); #1;
    chk("mid_rst_reg_q", bus.reg_q, 32'h0);
    reset = 1'b0;
    #1 chk("mid_first_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    chk("mid_next_reg_en", 32'(bus.reg_en), 32'h8);
    chk("mid_reg_q3", 32'(bus.reg_q[31:24]), 32'h0);
    $display("reset mid-op: reg_q=%h reg_en=%b", bus.reg_q, bus.reg_en);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
